// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data-memory port between the CPU MEM stage and the debug read path.
// Optional DMEM_ARB_STATS_EN adds saturating forced-slot and stall counters.
module dmem_port_arbiter #(
    parameter int AW         = 12,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 15
) (
    input  logic          in_CLK,
    input  logic          in_RST,
    input  logic          cpu_re,
    input  logic          cpu_we,
    input  logic          cpu_half,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_we,
    output logic          mem_half,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_force,
    output logic [15:0]   stat_stall
`endif
);
    localparam logic [1:0] IDLE      = 2'b00;
    localparam logic [1:0] CPU_OWN   = 2'b01;
    localparam logic [1:0] DBG_OWN   = 2'b10;
    localparam logic [1:0] DBG_FORCE = 2'b11;
    localparam logic [7:0] CNT_MAX   = 8'(STARVE_MAX);
    logic [1:0]    state, decision;
    logic [7:0]    starve_cnt, cnt_next;
    logic          cpu_acc, force_slot, owner_q, cpu_rd_q;
    logic [DW-1:0] dbg_hold, cpu_hold;
    // The decision is gated by reset so the port is quiet while in_RST is held.
    always_comb begin
        cpu_acc    = cpu_re | cpu_we;
        force_slot = !in_RST && dbg_req && starve_cnt == CNT_MAX && state != DBG_FORCE;
        decision   = in_RST ? IDLE : force_slot ? DBG_FORCE : cpu_acc ? CPU_OWN : dbg_req ? DBG_OWN : IDLE;
        dbg_gnt    = decision[1];
        cpu_stall  = decision == DBG_FORCE && cpu_acc;
        mem_we     = decision == CPU_OWN && cpu_we;
        mem_half   = decision == CPU_OWN && cpu_half;
        mem_addr   = dbg_gnt ? dbg_addr : cpu_addr;
        mem_wdata  = cpu_wdata;
        cnt_next   = (decision == CPU_OWN && dbg_req) ? (starve_cnt == CNT_MAX ? starve_cnt : starve_cnt + 8'd1) : 8'd0;
    end
    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            state      <= IDLE;
            starve_cnt <= 8'd0;
            owner_q    <= 1'b0;
            cpu_rd_q   <= 1'b0;
            dbg_hold   <= '0;
            cpu_hold   <= '0;
        end else begin
            state      <= decision;
            starve_cnt <= cnt_next;
            owner_q    <= dbg_gnt;
            cpu_rd_q   <= decision == CPU_OWN && cpu_re && !cpu_we;
            if (owner_q) dbg_hold <= mem_rdata;
            if (cpu_rd_q) cpu_hold <= mem_rdata;
        end
    end
    // Read data is live from memory in the cycle after a grant, then held.
    assign dbg_rvalid = owner_q;
    assign dbg_rdata  = owner_q ? mem_rdata : dbg_hold;
    assign cpu_rdata  = cpu_rd_q ? mem_rdata : cpu_hold;
`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            stat_force <= 16'd0;
            stat_stall <= 16'd0;
        end else begin
            if (decision == DBG_FORCE && stat_force != 16'hFFFF) stat_force <= stat_force + 16'd1;
            if (cpu_stall && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
        end
    end
`endif
endmodule
